collision_scan: RTL and testbench

- Parametrised successor to the four-car frog collision checker. Checks one frog box against NUM_OBJ object boxes (cars, logs, hazards), one per clock, once per frame tick.
- Reports the lowest-index overlapping object and a debounced collision flag that needs HIT_FRAMES consecutive hit frames.
- Sits between the object position generators and the game-state/lives logic.

---
 rtl/collision_scan.sv | 219 +++++++++++++++++++++
 tb/tb_collision_scan.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scan.sv
// collision_scan
//   Tests one frog box against NUM_OBJ object boxes, one object per clock,
//   once per frame tick. Reports the lowest-index overlapping object and a
//   collision flag that only asserts after HIT_FRAMES consecutive hit frames.
//
//   Pipeline: p0 = snapshot of all coordinates taken on the accepted tick,
//             p1 = registered hit result of the object tested last cycle,
//             which is folded into the per-frame hit state on the next edge.
//
// Ports
//   clk_in, reset_in          clock, asynchronous active-high reset
//   enable_in                 game-running qualifier; low aborts scan, clears flag
//   frame_tick_in             one-cycle pulse starting a scan
//   frogL/R, frogT/B          frog box edges
//   objL_in/R_in/T_in/B_in    packed object edges, object i at [i*W +: W]
//   obj_valid_in              per-object enable
//   collision_o               debounced collision flag
//   hit_idx_o                 lowest hit object index of the last hit frame
//   done_o                    one-cycle pulse at scan completion
//   busy_o                    high while scanning or in the done cycle
//   overrun_o                 one-cycle pulse for a tick that arrives while busy
module collision_scan #(
  parameter int NUM_OBJ    = 8,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int HIT_FRAMES = 1,
  parameter int INCLUSIVE  = 0
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic                  frame_tick_in,
  input  logic [XW-1:0]         frogL,
  input  logic [XW-1:0]         frogR,
  input  logic [YW-1:0]         frogT,
  input  logic [YW-1:0]         frogB,
  input  logic [NUM_OBJ*XW-1:0] objL_in,
  input  logic [NUM_OBJ*XW-1:0] objR_in,
  input  logic [NUM_OBJ*YW-1:0] objT_in,
  input  logic [NUM_OBJ*YW-1:0] objB_in,
  input  logic [NUM_OBJ-1:0]    obj_valid_in,
  output logic                  collision_o,
  output logic [3:0]            hit_idx_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int         MAXO = 16;
  localparam logic [4:0] NOBJ = 5'(NUM_OBJ);
  localparam logic [3:0] HF   = 4'(HIT_FRAMES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Edge test; all comparisons unsigned at coordinate width.
  function automatic logic box_hit(input logic [XW-1:0] fl, input logic [XW-1:0] fr,
                                   input logic [XW-1:0] ol, input logic [XW-1:0] orr,
                                   input logic [YW-1:0] ft, input logic [YW-1:0] fb,
                                   input logic [YW-1:0] ot, input logic [YW-1:0] ob);
    if (INCLUSIVE != 0)
      return (fr >= ol) && (fl <= orr) && (fb >= ot) && (ft <= ob);
    else
      return (fr > ol) && (fl < orr) && (fb > ot) && (ft < ob);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= HF) ? HF : c + 4'd1;
  endfunction

  // Objects are unpacked into fixed 16-entry arrays so a 4-bit index always
  // fits; entries beyond NUM_OBJ are tied off and never marked valid.
  logic [XW-1:0]   obj_l_w [MAXO];
  logic [XW-1:0]   obj_r_w [MAXO];
  logic [YW-1:0]   obj_t_w [MAXO];
  logic [YW-1:0]   obj_b_w [MAXO];
  logic [MAXO-1:0] obj_vld_w;

  for (genvar g = 0; g < MAXO; g++) begin : g_unpack
    if (g < NUM_OBJ) begin : g_live
      assign obj_l_w[g]   = objL_in[g*XW +: XW];
      assign obj_r_w[g]   = objR_in[g*XW +: XW];
      assign obj_t_w[g]   = objT_in[g*YW +: YW];
      assign obj_b_w[g]   = objB_in[g*YW +: YW];
      assign obj_vld_w[g] = obj_valid_in[g];
    end else begin : g_pad
      assign obj_l_w[g]   = '0;
      assign obj_r_w[g]   = '0;
      assign obj_t_w[g]   = '0;
      assign obj_b_w[g]   = '0;
      assign obj_vld_w[g] = 1'b0;
    end
  end

  state_t          state;
  logic [4:0]      idx;
  logic            frame_hit;
  logic [3:0]      hit_idx_tmp;
  logic [3:0]      cnt;

  logic [XW-1:0]   frog_l_p0, frog_r_p0;
  logic [YW-1:0]   frog_t_p0, frog_b_p0;
  logic [XW-1:0]   obj_l_p0 [MAXO];
  logic [XW-1:0]   obj_r_p0 [MAXO];
  logic [YW-1:0]   obj_t_p0 [MAXO];
  logic [YW-1:0]   obj_b_p0 [MAXO];
  logic [MAXO-1:0] obj_vld_p0;

  logic            hit_p1;
  logic            vld_p1;
  logic [3:0]      idx_p1;

  logic [3:0]      sel;
  logic            hit_now;
  logic            fh_next;
  logic [3:0]      tmp_next;
  logic [3:0]      cnt_next;

  // Stage p0 -> p1: test the snapshot object addressed by idx.
  always_comb begin
    sel      = idx[3:0];
    hit_now  = obj_vld_p0[sel] &&
               box_hit(frog_l_p0, frog_r_p0, obj_l_p0[sel], obj_r_p0[sel],
                       frog_t_p0, frog_b_p0, obj_t_p0[sel], obj_b_p0[sel]);
    // Stage p1 -> frame state: first hit of the frame wins.
    fh_next  = frame_hit | (vld_p1 & hit_p1);
    tmp_next = frame_hit ? hit_idx_tmp : idx_p1;
    cnt_next = fh_next ? sat_inc(cnt) : 4'd0;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      idx         <= '0;
      frame_hit   <= 1'b0;
      hit_idx_tmp <= '0;
      cnt         <= '0;
      collision_o <= 1'b0;
      hit_idx_o   <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      frog_l_p0   <= '0;
      frog_r_p0   <= '0;
      frog_t_p0   <= '0;
      frog_b_p0   <= '0;
      obj_vld_p0  <= '0;
      for (int i = 0; i < MAXO; i++) begin
        obj_l_p0[i] <= '0;
        obj_r_p0[i] <= '0;
        obj_t_p0[i] <= '0;
        obj_b_p0[i] <= '0;
      end
      hit_p1      <= 1'b0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
    end else begin
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      if (!enable_in) begin
        state       <= IDLE;
        busy_o      <= 1'b0;
        cnt         <= '0;
        collision_o <= 1'b0;
        vld_p1      <= 1'b0;
      end else begin
        overrun_o <= frame_tick_in && (state != IDLE);
        case (state)
          IDLE: begin
            if (frame_tick_in) begin
              frog_l_p0  <= frogL;
              frog_r_p0  <= frogR;
              frog_t_p0  <= frogT;
              frog_b_p0  <= frogB;
              obj_vld_p0 <= obj_vld_w;
              for (int i = 0; i < MAXO; i++) begin
                obj_l_p0[i] <= obj_l_w[i];
                obj_r_p0[i] <= obj_r_w[i];
                obj_t_p0[i] <= obj_t_w[i];
                obj_b_p0[i] <= obj_b_w[i];
              end
              idx       <= '0;
              frame_hit <= 1'b0;
              vld_p1    <= 1'b0;
              state     <= SCAN;
              busy_o    <= 1'b1;
            end
          end
          SCAN: begin
            frame_hit <= fh_next;
            if (fh_next) hit_idx_tmp <= tmp_next;
            if (idx < NOBJ) begin
              hit_p1 <= hit_now;
              idx_p1 <= sel;
              vld_p1 <= 1'b1;
              idx    <= idx + 5'd1;
            end else begin
              // Last object's result has drained from p1; close the frame.
              vld_p1      <= 1'b0;
              state       <= DONE;
              done_o      <= 1'b1;
              cnt         <= cnt_next;
              collision_o <= (cnt_next == HF);
              if (fh_next) hit_idx_o <= tmp_next;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
module tb_collision_scan;

  logic        clk, rst, en, tick;
  logic [9:0]  fl, fr;
  logic [8:0]  ft, fb;
  logic [39:0] ol, orr;
  logic [35:0] ot, ob;
  logic [3:0]  vld;

  logic       col0, done0, busy0, ovr0;
  logic [3:0] idx0;
  logic       col1, done1, busy1, ovr1;
  logic [3:0] idx1;
  logic       col3, done3, busy3, ovr3;
  logic [3:0] idx3;

  int n_tests = 0;
  int n_fail  = 0;

  collision_scan #(.NUM_OBJ(4), .XW(10), .YW(9), .HIT_FRAMES(1), .INCLUSIVE(0)) u_strict (
    .clk_in(clk), .reset_in(rst), .enable_in(en), .frame_tick_in(tick),
    .frogL(fl), .frogR(fr), .frogT(ft), .frogB(fb),
    .objL_in(ol), .objR_in(orr), .objT_in(ot), .objB_in(ob), .obj_valid_in(vld),
    .collision_o(col0), .hit_idx_o(idx0), .done_o(done0), .busy_o(busy0), .overrun_o(ovr0));

  collision_scan #(.NUM_OBJ(4), .XW(10), .YW(9), .HIT_FRAMES(1), .INCLUSIVE(1)) u_incl (
    .clk_in(clk), .reset_in(rst), .enable_in(en), .frame_tick_in(tick),
    .frogL(fl), .frogR(fr), .frogT(ft), .frogB(fb),
    .objL_in(ol), .objR_in(orr), .objT_in(ot), .objB_in(ob), .obj_valid_in(vld),
    .collision_o(col1), .hit_idx_o(idx1), .done_o(done1), .busy_o(busy1), .overrun_o(ovr1));

  collision_scan #(.NUM_OBJ(4), .XW(10), .YW(9), .HIT_FRAMES(3), .INCLUSIVE(0)) u_deb (
    .clk_in(clk), .reset_in(rst), .enable_in(en), .frame_tick_in(tick),
    .frogL(fl), .frogR(fr), .frogT(ft), .frogB(fb),
    .objL_in(ol), .objR_in(orr), .objT_in(ot), .objB_in(ob), .obj_valid_in(vld),
    .collision_o(col3), .hit_idx_o(idx3), .done_o(done3), .busy_o(busy3), .overrun_o(ovr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int i, input logic [9:0] l, input logic [9:0] r,
                         input logic [8:0] t, input logic [8:0] b);
    ol[i*10 +: 10]  = l;
    orr[i*10 +: 10] = r;
    ot[i*9 +: 9]    = t;
    ob[i*9 +: 9]    = b;
  endtask

  task automatic far(input int i);
    set_obj(i, 10'd600, 10'd620, 9'd400, 9'd420);
  endtask

  // Pulses tick for one edge (E0) and waits for done_o; returns edges after E0.
  task automatic do_frame(output int lat);
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 0;
    while (done0 !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    n_tests++;
    if (lat >= 20) begin
      $display("FAIL frame_timeout waited=%0d cycles, required done_o within 5", lat);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_tests++; if ({col0, idx0, done0, busy0, ovr0} !== 8'h00) begin $display("FAIL reset_strict act=%h exp=00", {col0, idx0, done0, busy0, ovr0}); n_fail++; end
    n_tests++; if ({col1, idx1, done1, busy1, ovr1} !== 8'h00) begin $display("FAIL reset_incl act=%h exp=00", {col1, idx1, done1, busy1, ovr1}); n_fail++; end
    n_tests++; if ({col3, idx3, done3, busy3, ovr3} !== 8'h00) begin $display("FAIL reset_deb act=%h exp=00", {col3, idx3, done3, busy3, ovr3}); n_fail++; end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    set_obj(2, 10'd110, 10'd140, 9'd205, 9'd220);
    do_frame(lat);
    n_tests++; if (lat != 5) begin $display("FAIL basic_latency act=%0d exp=5", lat); n_fail++; end
    n_tests++; if (col0 !== 1'b1) begin $display("FAIL basic_col act=%b exp=1", col0); n_fail++; end
    n_tests++; if (idx0 !== 4'd2) begin $display("FAIL basic_idx act=%0d exp=2", idx0); n_fail++; end
    n_tests++; if (busy0 !== 1'b1) begin $display("FAIL basic_busy_done act=%b exp=1", busy0); n_fail++; end
    n_tests++; if (col3 !== 1'b0) begin $display("FAIL basic_deb_col act=%b exp=0", col3); n_fail++; end
    step();
    n_tests++; if ({done0, busy0} !== 2'b00) begin $display("FAIL basic_after act=%b exp=00", {done0, busy0}); n_fail++; end
  endtask

  task automatic test_lowest();
    int lat;
    far(2);
    set_obj(1, 10'd90, 10'd105, 9'd190, 9'd205);
    set_obj(3, 10'd112, 10'd130, 9'd210, 9'd230);
    do_frame(lat);
    n_tests++; if (col0 !== 1'b1) begin $display("FAIL lowest_col act=%b exp=1", col0); n_fail++; end
    n_tests++; if (idx0 !== 4'd1) begin $display("FAIL lowest_idx act=%0d exp=1", idx0); n_fail++; end
    step();
    far(1); far(3);
    do_frame(lat);
    n_tests++; if (col0 !== 1'b0) begin $display("FAIL nohit_col act=%b exp=0", col0); n_fail++; end
    n_tests++; if (idx0 !== 4'd1) begin $display("FAIL nohit_idx_hold act=%0d exp=1", idx0); n_fail++; end
    step();
  endtask

  task automatic test_touch();
    int lat;
    fr = 10'd110;
    set_obj(0, 10'd110, 10'd140, 9'd205, 9'd220);
    do_frame(lat);
    n_tests++; if (col0 !== 1'b0) begin $display("FAIL touch_strict_col act=%b exp=0", col0); n_fail++; end
    n_tests++; if (col1 !== 1'b1) begin $display("FAIL touch_incl_col act=%b exp=1", col1); n_fail++; end
    n_tests++; if (idx1 !== 4'd0) begin $display("FAIL touch_incl_idx act=%0d exp=0", idx1); n_fail++; end
    step();
    fr = 10'd116;
    far(0);
  endtask

  task automatic test_debounce();
    int lat;
    bit hitv [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 1};
    bit expv [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 10; k++) begin
      if (hitv[k]) set_obj(2, 10'd110, 10'd140, 9'd205, 9'd220);
      else far(2);
      do_frame(lat);
      n_tests++; if (col3 !== expv[k]) begin $display("FAIL debounce_frame%0d act=%b exp=%b", k, col3, expv[k]); n_fail++; end
      step();
    end
  endtask

  task automatic test_valid();
    int lat;
    set_obj(2, 10'd110, 10'd140, 9'd205, 9'd220);
    vld = 4'b1011;
    do_frame(lat);
    n_tests++; if (col0 !== 1'b0) begin $display("FAIL invalid_obj_col act=%b exp=0", col0); n_fail++; end
    n_tests++; if (idx0 !== 4'd2) begin $display("FAIL invalid_obj_idx act=%0d exp=2", idx0); n_fail++; end
    step();
    vld = 4'hF;
  endtask

  task automatic test_overrun();
    int extra;
    set_obj(2, 10'd110, 10'd140, 9'd205, 9'd220);
    tick = 1'b1;
    step();                       // E0
    tick = 1'b0;
    far(2);                       // snapshot must still hold the overlap
    n_tests++; if ({busy0, ovr0} !== 2'b10) begin $display("FAIL ovr_start act=%b exp=10", {busy0, ovr0}); n_fail++; end
    step();                       // E1
    tick = 1'b1;
    step();                       // E2
    tick = 1'b0;
    n_tests++; if (ovr0 !== 1'b1) begin $display("FAIL ovr_pulse act=%b exp=1", ovr0); n_fail++; end
    step();                       // E3
    n_tests++; if (ovr0 !== 1'b0) begin $display("FAIL ovr_one_cycle act=%b exp=0", ovr0); n_fail++; end
    step();                       // E4
    n_tests++; if (done0 !== 1'b0) begin $display("FAIL ovr_early_done act=%b exp=0", done0); n_fail++; end
    step();                       // E5
    n_tests++; if ({done0, col0, idx0} !== 6'b11_0010) begin $display("FAIL ovr_done act=%b exp=110010", {done0, col0, idx0}); n_fail++; end
    extra = 0;
    repeat (4) begin
      step();
      if (busy0 || done0) extra++;
    end
    n_tests++; if (extra != 0) begin $display("FAIL ovr_no_rescan act=%0d busy cycles exp=0", extra); n_fail++; end
  endtask

  task automatic test_enable();
    int lat;
    int dones;
    set_obj(2, 10'd110, 10'd140, 9'd205, 9'd220);
    tick = 1'b1;
    step();                       // E0
    tick = 1'b0;
    step();                       // E1
    step();                       // E2
    en = 1'b0;
    step();                       // E3
    n_tests++; if ({busy0, col0} !== 2'b00) begin $display("FAIL en_abort act=%b exp=00", {busy0, col0}); n_fail++; end
    dones = 0;
    repeat (6) begin
      step();
      if (done0) dones++;
    end
    n_tests++; if (dones != 0) begin $display("FAIL en_no_done act=%0d exp=0", dones); n_fail++; end
    n_tests++; if (idx0 !== 4'd2) begin $display("FAIL en_idx_hold act=%0d exp=2", idx0); n_fail++; end
    en = 1'b1;                    // rises together with the tick
    do_frame(lat);
    n_tests++; if (lat != 5 || col0 !== 1'b1) begin $display("FAIL en_rise_tick lat=%0d col=%b exp lat=5 col=1", lat, col0); n_fail++; end
    step();
  endtask

  task automatic test_reset_mid();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    n_tests++; if ({busy0, col0} !== 2'b11) begin $display("FAIL rstmid_pre act=%b exp=11", {busy0, col0}); n_fail++; end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({col0, idx0, done0, busy0, ovr0} !== 8'h00) begin $display("FAIL rstmid_async act=%h exp=00", {col0, idx0, done0, busy0, ovr0}); n_fail++; end
    n_tests++; if ({col1, idx1, busy1} !== 6'h00) begin $display("FAIL rstmid_async_incl act=%h exp=00", {col1, idx1, busy1}); n_fail++; end
    #3 rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tick = 1'b0;
    fl = 10'd100; fr = 10'd116; ft = 9'd200; fb = 9'd216;
    ol = '0; orr = '0; ot = '0; ob = '0;
    for (int i = 0; i < 4; i++) far(i);
    vld = 4'hF;
    test_reset();
    test_basic();
    test_lowest();
    test_touch();
    test_debounce();
    test_valid();
    test_overrun();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
